// File: rtl/key_if_pkg.sv
// Shared definitions for the key-load source side of the consumer interface.
//   KEY_W         key width, equal to the consumer's X_load width
//   DEF_NUM_KEYS  default number of keys streamed per run
//   state_t       run-sequencer states
package key_if_pkg;

  localparam int KEY_W        = 7;
  localparam int DEF_NUM_KEYS = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_FIN = 3'd4
  } state_t;

endpackage

// File: rtl/key_mem.sv
// Key storage: DEPTH x W, one write port and one synchronous read port.
//   clk      rising-edge clock
//   we/wa/wd write strobe, address, data
//   re/ra    read enable and address; rd_data updates on the next edge
//   rd_data  registered read data, holds its value while re is low
// A read and a write to the same address on the same edge return the new
// data, so a key written in the go cycle is the one that gets streamed.
module key_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 7,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd_data <= (we && (wa == ra)) ? wd : mem[ra];
  end

endmodule

// File: rtl/key_stream_src.sv
// Source side of the key-load interface: holds NUM_KEYS keys written by a
// host, and on go pulses start_in, streams every key in address order with
// valid_input, waits for finish and reports done/result or a timeout.
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data    host key writes, accepted only while idle
//   go                       one-cycle run request, accepted only while idle
//   busy                     run in progress
//   start_in                 one-cycle start pulse to the consumer
//   valid_input/X_load       key stream to the consumer
//   finish/P_out             consumer completion and result bit
//   done                     one-cycle completion pulse
//   result                   P_out captured with finish, held until next done
//   timeout                  sticky abort flag, cleared by the next accepted go
//   state_dbg                current sequencer state
//
// Stream handshake: there is no back-pressure. A key is transferred on every
// cycle valid_input is high; X_load is a flop and reads 0 whenever
// valid_input is low.
module key_stream_src
  import key_if_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int KEY_W    = key_if_pkg::KEY_W,
  parameter int GAP      = 0,
  parameter int TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_KEYS)-1:0] wr_addr,
  input  logic [KEY_W-1:0]            wr_data,
  input  logic                        go,
  output logic                        busy,
  output logic                        start_in,
  output logic                        valid_input,
  output logic [KEY_W-1:0]            X_load,
  input  logic                        finish,
  input  logic                        P_out,
  output logic                        done,
  output logic                        result,
  output logic                        timeout,
  output logic [2:0]                  state_dbg
);

  localparam int AW = $clog2(NUM_KEYS);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_KEYS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [GW-1:0]   gcnt, gcnt_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            done_nxt, result_nxt, timeout_nxt;
  logic            load;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [KEY_W-1:0] rd_data;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gcnt_nxt    = gcnt;
    tcnt_nxt    = tcnt;
    done_nxt    = 1'b0;
    result_nxt  = result;
    timeout_nxt = timeout;
    case (state)
      ST_IDLE: begin
        // A go coinciding with the done pulse belongs to the finished run.
        if (go && !done) begin
          state_nxt   = ST_START;
          idx_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_START: begin
        state_nxt = ST_SEND;
        idx_nxt   = '0;
      end
      ST_SEND: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_WAIT_FIN;
          tcnt_nxt  = '0;
        end else if (GAP > 0) begin
          state_nxt = ST_GAP;
          gcnt_nxt  = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt = ST_SEND;
          idx_nxt   = idx + AW'(1);
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      ST_WAIT_FIN: begin
        if (finish) begin
          state_nxt  = ST_IDLE;
          result_nxt = P_out;
          done_nxt   = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_nxt = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rd_data always holds the next key to send, so X_load loads straight from
  // a flop. The first key is fetched on the go edge; every load of X_load
  // fetches the following key.
  always_comb begin
    load    = (state_nxt == ST_SEND);
    rd_en   = load || (state_nxt == ST_START);
    rd_addr = ((state_nxt == ST_START) || (idx_nxt == LAST_IDX)) ? '0 : idx_nxt + AW'(1);
  end

  key_mem #(
    .DEPTH (NUM_KEYS),
    .W     (KEY_W),
    .AW    (AW)
  ) u_key_mem (
    .clk     (clk),
    .we      (wr_en && (state == ST_IDLE)),
    .wa      (wr_addr),
    .wd      (wr_data),
    .re      (rd_en),
    .ra      (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      gcnt    <= '0;
      tcnt    <= '0;
      X_load  <= '0;
      done    <= 1'b0;
      result  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gcnt    <= gcnt_nxt;
      tcnt    <= tcnt_nxt;
      X_load  <= load ? rd_data : '0;
      done    <= done_nxt;
      result  <= result_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Decoded straight from the state flop so reset removes them immediately.
  assign busy        = (state != ST_IDLE);
  assign start_in    = (state == ST_START);
  assign valid_input = (state == ST_SEND);
  assign state_dbg   = state;

endmodule
